// File: rtl/wb_bram_burst.sv
// Wishbone B4 slave on an inferred single-port BlockRAM: byte-lane writes,
// classic reads with one wait state, and incrementing/wrapping read bursts.
module wb_bram_burst #(
  parameter int mem_adr_width = 11,
  parameter int data_width    = 32,
  parameter int adr_width     = 32,
  parameter bit range_check   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [adr_width-1:0]    adr,
  input  logic [data_width/8-1:0] sel,
  input  logic [data_width-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [data_width-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err,
  output logic                    rty
);

  localparam int NB    = data_width / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << mem_adr_width;
  localparam int TOPB  = mem_adr_width + OFF;
  localparam logic [mem_adr_width-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RD, RD_BURST} state_t;

  state_t                   state_q, state_d;
  logic [mem_adr_width-1:0] cur_q, cur_d;
  logic                     oor_q, oor_d;
  logic [data_width-1:0]    hold_q;
  logic [data_width-1:0]    ram_q;
  logic [data_width-1:0]    mem [DEPTH];

  logic [mem_adr_width-1:0] word;
  logic [mem_adr_width-1:0] rd_idx;
  logic                     req, oor, wr_en, rd_en, rd_ack, rd_err;

  function automatic logic addr_oor(input logic [adr_width-1:0] a);
    logic [adr_width-1:0] hi;
    hi = a >> TOPB;
    return range_check && (hi != '0);
  endfunction

  // Wrapping bursts only advance the low 2/3/4 index bits; linear uses all.
  function automatic logic [mem_adr_width-1:0] wrap_next(
    input logic [mem_adr_width-1:0] cur,
    input logic [1:0]               b
  );
    logic [mem_adr_width-1:0] inc, mask;
    inc  = cur + ONE;
    mask = '0;
    case (b)
      2'b01:   mask[1:0] = 2'b11;
      2'b10:   mask[2:0] = 3'b111;
      2'b11:   mask[3:0] = 4'b1111;
      default: mask = '1;
    endcase
    return (cur & ~mask) | (inc & mask);
  endfunction

  // req is gated by reset so every termination drops asynchronously.
  assign req   = cyc & stb & rst;
  assign oor   = addr_oor(adr);
  assign word  = adr[TOPB-1:OFF];
  assign wr_en = req & we & ~oor;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    oor_d   = oor_q;
    rd_en   = 1'b0;
    rd_idx  = word;
    rd_ack  = 1'b0;
    rd_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !we) begin
          rd_en   = 1'b1;
          cur_d   = word;
          oor_d   = oor;
          state_d = (cti == 3'b010) ? RD_BURST : RD;
        end
      end
      RD: begin
        rd_ack  = req & ~oor_q;
        rd_err  = req & oor_q;
        state_d = IDLE;
      end
      RD_BURST: begin
        if (!cyc) begin
          state_d = IDLE;
        end else if (req) begin
          rd_ack = ~oor_q;
          rd_err = oor_q;
          rd_en  = 1'b1;
          rd_idx = wrap_next(cur_q, bte);
          cur_d  = rd_idx;
          if (cti != 3'b010) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      oor_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      oor_q   <= oor_d;
      if (rd_ack) hold_q <= ram_q;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en && sel[i]) mem[word][8*i +: 8] <= dat_ms[8*i +: 8];
    end
    if (rd_en) ram_q <= mem[rd_idx];
  end

  assign dat_sm = rd_ack ? ram_q : hold_q;
  assign ack    = wr_en | rd_ack;
  assign err    = (req & we & oor) | rd_err;
  assign rty    = 1'b0;

endmodule

// File: doc/wb_bram_burst.md
Name: wb_bram_burst

Overview:
Parametrised Wishbone B4 (classic + registered-feedback burst) slave wrapping an inferred single-port BlockRAM. It is the next-generation on-chip memory for the memory-controller subsystem. Relative to the basic slave it adds:
- real storage with byte-lane writes;
- configurable data width and depth;
- incrementing and wrapping bursts at one word per clock;
- an address-range error response.

Parameters:
- mem_adr_width, 11, log2 of memory depth in words (2048 words at default).
- data_width, 32, data bus width in bits; multiple of 8, power of 2, 8..128.
- adr_width, 32, Wishbone byte-address width; must be ≥ mem_adr_width+OFF, where OFF = log2(data_width/8).
- range_check, 1, when 1 an out-of-range address is answered with err instead of ack.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cyc  in  1  Wishbone cycle valid.
- stb  in  1  Wishbone strobe.
- we  in  1  write enable.
- adr  in  adr_width  byte address; word index = adr[mem_adr_width+OFF-1:OFF].
- sel  in  data_width/8  byte-lane selects.
- dat_ms  in  data_width  write data (master to slave).
- cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; others treated as 000.
- bte  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- dat_sm  out  data_width  read data (slave to master).
- ack  out  1  normal termination.
- err  out  1  error termination.
- rty  out  1  retry; tied 0.

Behaviour:
- One clock, asynchronous active-low reset.
- While rst=0, asynchronously: ack=0, err=0, rty=0, dat_sm=0, FSM=IDLE, burst address counter=0. RAM contents are not cleared and are unchanged by reset.
- Valid request: req = cyc & stb.
- Out-of-range (oor): range_check=1 and any adr bit above mem_adr_width+OFF-1 is nonzero. An oor request receives err at the cycle ack would have taken, with no RAM write. err and ack are never both 1.

Writes:
- ack is combinational: ack = req & we & ~oor in the same cycle.
- Byte lane i of RAM[word] is written at that rising edge iff sel[i]=1.
- Back-to-back writes complete at one per clock, classic or burst.
- cti/bte are ignored for write addressing; the address comes from adr.

Reads (FSM states IDLE, RD, RD_BURST):
- IDLE:
  - req & ~we presents adr to the RAM.
  - Next state is RD_BURST if cti=010, else RD.
  - ack=0 during this cycle (one wait state).
- RD:
  - ack=1 (or err if oor) for exactly one cycle; dat_sm = RAM[word sampled in IDLE].
  - Then go to IDLE. This forces ack low for one cycle, so a held stb never double-acks.
- RD_BURST:
  - ack=1 every cycle in which stb=1.
  - The RAM address advances one word ahead, so data is available at one word per clock.
  - Next word index = wrap(cur+1). For bte=01/10/11, only the low 2/3/4 bits of the word index increment modulo 4/8/16; upper bits are held. bte=00 is linear, modulo 2**mem_adr_width.
  - stb=0 (master wait state): ack=0, address and dat_sm hold, no advance.
  - Leave to IDLE after acking a beat with cti=111, or when cyc=0.
  - If the master abandons a burst with cti changed to 000, the current beat is acked and the FSM returns to IDLE.
- cyc=0 in any state: return to IDLE next clock; ack=0 combinationally.
- dat_sm holds its last value when ack=0; it is undefined-free (never X) after reset.
- Read latency: classic 1 wait state; burst first beat 1 wait state, subsequent beats 0.
- Read-during-write: cannot occur (single master, single port).

Test Plan:
- Reset mid-burst: rst=0 during RD_BURST -> ack, err, dat_sm go to 0 immediately; after release, a read of 0x10 still returns the pre-reset contents.
- Classic write then read: write 0xDEADBEEF at adr 0x40, sel=F -> ack same cycle. Read 0x40 -> ack exactly one cycle later, dat_sm=0xDEADBEEF, and ack=0 the following cycle with stb held.
- Byte lanes: word 0x80=0x11223344, write 0xAABBCCDD with sel=0101 -> readback 0x11BB33DD.
- Linear burst: preload words 0..7 with value=index. Read burst from word 2, cti=010 for 3 beats then 111 -> ack on 4 consecutive cycles after 1 wait state, data 2,3,4,5, then FSM IDLE.
- Wrap-4 burst with a master stall: start word 6, bte=01, 4 beats, stb=0 for 2 cycles after beat 2 -> data 6,7,4,5; no ack while stb=0.
- Range error (range_check=1, default sizes): read adr 0x2000 -> err=1 one cycle later, ack=0. Write adr 0x2000 -> err same cycle, RAM word 0 unchanged.
